sd_init_seq: RTL and testbench



---
 rtl/sd_init_seq_pkg.sv | 93 +++++++++
 rtl/sd_timer.sv | 41 ++++
 rtl/sd_init_seq.sv | 212 +++++++++++++++++++++
 tb/tb_sd_init_seq.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_init_seq_pkg.sv
// ---------------------------------------------------------------------------
// sd_init_seq_pkg
// Shared SD SPI-mode constants: command indices, command arguments, expected
// R1 values, init error codes and the sequencer state/step encodings. The
// command constants are also used by sd_cmd_gen, so both blocks agree on them.
// ---------------------------------------------------------------------------
package sd_init_seq_pkg;

    // SD command indices
    localparam logic [5:0] CMD_GO_IDLE_STATE   = 6'd0;
    localparam logic [5:0] CMD_SEND_IF_COND    = 6'd8;
    localparam logic [5:0] CMD_SET_BLOCKLEN    = 6'd16;
    localparam logic [5:0] CMD_SD_SEND_OP_COND = 6'd41;
    localparam logic [5:0] CMD_APP_CMD         = 6'd55;

    // Command arguments: 2.7-3.6V with check pattern AA, HCS request,
    // 512-byte blocks
    localparam logic [31:0] ARG_NONE   = 32'h0000_0000;
    localparam logic [31:0] ARG_CMD8   = 32'h0000_01AA;
    localparam logic [31:0] ARG_ACMD41 = 32'h4000_0000;
    localparam logic [31:0] ARG_CMD16  = 32'h0000_0200;

    // R1 responses the sequence expects
    localparam logic [7:0] R1_IDLE  = 8'h01;
    localparam logic [7:0] R1_READY = 8'h00;

    // Error codes reported on err_code (0 means no error)
    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_CMD0    = 3'd1;
    localparam logic [2:0] ERR_CMD8    = 3'd2;
    localparam logic [2:0] ERR_ACMD41  = 3'd3;
    localparam logic [2:0] ERR_CMD16   = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT = 3'd5;
    localparam logic [2:0] ERR_CMD55   = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PWRUP,
        ST_ISSUE,
        ST_WAIT,
        ST_EVAL,
        ST_DONE,
        ST_ERROR
    } state_t;

    typedef enum logic [2:0] {
        S_CMD0,
        S_CMD8,
        S_CMD55,
        S_ACMD41,
        S_CMD16
    } step_t;

    typedef struct packed {
        logic [5:0]  cmd;
        logic [31:0] arg;
        logic        ignore_count;
    } cmd_fields_t;

    // Command index, argument and R7-discard flag for one step of the sequence
    function automatic cmd_fields_t step_fields(input step_t step);
        cmd_fields_t f;
        f.cmd          = CMD_GO_IDLE_STATE;
        f.arg          = ARG_NONE;
        f.ignore_count = 1'b0;
        case (step)
            S_CMD0: begin
                f.cmd = CMD_GO_IDLE_STATE;
            end
            S_CMD8: begin
                f.cmd          = CMD_SEND_IF_COND;
                f.arg          = ARG_CMD8;
                f.ignore_count = 1'b1;
            end
            S_CMD55: begin
                f.cmd = CMD_APP_CMD;
            end
            S_ACMD41: begin
                f.cmd = CMD_SD_SEND_OP_COND;
                f.arg = ARG_ACMD41;
            end
            S_CMD16: begin
                f.cmd = CMD_SET_BLOCKLEN;
                f.arg = ARG_CMD16;
            end
            default: begin
                f.cmd = CMD_GO_IDLE_STATE;
            end
        endcase
        return f;
    endfunction

endpackage

// File: rtl/sd_timer.sv
// ---------------------------------------------------------------------------
// sd_timer
// Loadable down-counter with a terminal flag. The same counter times the
// card power-up wait and the per-command watchdog.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   load        - load load_value (has priority over enable)
//   load_value  - count to load
//   enable      - decrement by one per cycle, saturating at 0
//   expired     - high in the last counted cycle (count <= 1), so a value N
//                 loaded at an edge gives N enabled cycles before expiry acts
// ---------------------------------------------------------------------------
module sd_timer #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Down-counter: load wins over decrement, and the count parks at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // Expired once the count is 0 or 1, so the state acting on it leaves
    // exactly when the loaded number of cycles has elapsed.
    assign expired = (count[WIDTH-1:1] == '0);

endmodule

// File: rtl/sd_init_seq.sv
// ---------------------------------------------------------------------------
// sd_init_seq
// SD-card SPI-mode initialisation sequencer. After start it waits for card
// power-up, then runs CMD0, CMD8, the CMD55/ACMD41 loop and CMD16 through the
// sd_cmd_gen cmd/arg/go handshake, checking every R1 byte.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start           - one-cycle (re)initialise request, ignored while busy
//   busy            - sequence in progress
//   init_done       - card ready, held until next start/rst
//   init_error      - sequence failed, held until next start/rst
//   err_code        - failure cause (1 CMD0, 2 CMD8, 3 ACMD41, 4 CMD16,
//                     5 timeout, 6 CMD55)
//   cmd, arg, go    - command launch towards sd_cmd_gen
//   ignore_count    - discard the 4 trailing R7 bytes (CMD8 only)
//   cmd_done        - command transaction complete
//   response        - R1 byte, valid while response_ready
// ---------------------------------------------------------------------------
module sd_init_seq
    import sd_init_seq_pkg::*;
#(
    parameter logic [15:0] POWERUP_CYCLES = 16'd1000,
    parameter logic [3:0]  CMD0_RETRIES   = 4'd8,
    parameter logic [15:0] ACMD41_RETRIES = 16'd1000,
    parameter logic [23:0] CMD_TIMEOUT    = 24'd200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        init_done,
    output logic        init_error,
    output logic [2:0]  err_code,
    output logic [5:0]  cmd,
    output logic [31:0] arg,
    output logic        go,
    output logic        ignore_count,
    input  logic        cmd_done,
    input  logic [7:0]  response,
    input  logic        response_ready
);

    state_t      state, next_state;
    step_t       step, next_step;
    logic [2:0]  next_err;
    logic [3:0]  cmd0_count;
    logic [15:0] pair_count;
    logic [7:0]  resp_q;
    logic        resp_seen;
    logic        start_accept;
    logic        timer_load;
    logic        timer_enable;
    logic        timer_expired;
    logic [23:0] timer_value;

    assign busy         = (state == ST_PWRUP) || (state == ST_ISSUE) ||
                          (state == ST_WAIT)  || (state == ST_EVAL);
    assign init_done    = (state == ST_DONE);
    assign init_error   = (state == ST_ERROR);
    assign start_accept = start && !busy;

    // The timer is reloaded with the power-up time on an accepted start and
    // with the watchdog limit whenever a command is launched, so the watchdog
    // runs from the go cycle itself.
    assign timer_load   = start_accept || (next_state == ST_ISSUE);
    assign timer_value  = start_accept ? {8'd0, POWERUP_CYCLES} : CMD_TIMEOUT;
    assign timer_enable = (state == ST_PWRUP) || (state == ST_ISSUE) ||
                          (state == ST_WAIT);

    sd_timer #(.WIDTH(24)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (timer_value),
        .enable     (timer_enable),
        .expired    (timer_expired)
    );

    // Next-state logic. EVAL decides the next step from the latched R1 byte;
    // retry limits compare against attempts already issued, so a limit of N
    // allows exactly N CMD0s or N CMD55/ACMD41 pairs.
    always_comb begin
        next_state = state;
        next_step  = step;
        next_err   = err_code;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) next_state = ST_PWRUP;
            end
            ST_PWRUP: begin
                if (timer_expired) begin
                    next_state = ST_ISSUE;
                    next_step  = S_CMD0;
                end
            end
            ST_ISSUE: begin
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (cmd_done) begin
                    if (resp_seen || response_ready) begin
                        next_state = ST_EVAL;
                    end else begin
                        next_state = ST_ERROR;
                        next_err   = ERR_TIMEOUT;
                    end
                end else if (timer_expired) begin
                    next_state = ST_ERROR;
                    next_err   = ERR_TIMEOUT;
                end
            end
            ST_EVAL: begin
                next_state = ST_ISSUE;
                case (step)
                    S_CMD0: begin
                        if (resp_q == R1_IDLE) begin
                            next_step = S_CMD8;
                        end else if (cmd0_count >= CMD0_RETRIES) begin
                            next_state = ST_ERROR;
                            next_err   = ERR_CMD0;
                        end
                    end
                    S_CMD8: begin
                        if (resp_q == R1_IDLE) begin
                            next_step = S_CMD55;
                        end else begin
                            next_state = ST_ERROR;
                            next_err   = ERR_CMD8;
                        end
                    end
                    S_CMD55: begin
                        if ((resp_q == R1_IDLE) || (resp_q == R1_READY)) begin
                            next_step = S_ACMD41;
                        end else begin
                            next_state = ST_ERROR;
                            next_err   = ERR_CMD55;
                        end
                    end
                    S_ACMD41: begin
                        if (resp_q == R1_READY) begin
                            next_step = S_CMD16;
                        end else if ((resp_q == R1_IDLE) &&
                                     (pair_count < ACMD41_RETRIES)) begin
                            next_step = S_CMD55;
                        end else begin
                            next_state = ST_ERROR;
                            next_err   = ERR_ACMD41;
                        end
                    end
                    S_CMD16: begin
                        if (resp_q == R1_READY) begin
                            next_state = ST_DONE;
                        end else begin
                            next_state = ST_ERROR;
                            next_err   = ERR_CMD16;
                        end
                    end
                    default: begin
                        next_state = ST_IDLE;
                    end
                endcase
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs. Entering ISSUE is what launches
    // a command: go and the command fields are registered on that edge, so go
    // is high for the single ISSUE cycle and the fields stay put through WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            step         <= S_CMD0;
            cmd0_count   <= '0;
            pair_count   <= '0;
            resp_q       <= '0;
            resp_seen    <= 1'b0;
            go           <= 1'b0;
            cmd          <= '0;
            arg          <= '0;
            ignore_count <= 1'b0;
            err_code     <= ERR_NONE;
        end else begin
            state <= next_state;
            step  <= next_step;
            go    <= (next_state == ST_ISSUE);

            if (next_state == ST_ISSUE) begin
                {cmd, arg, ignore_count} <= step_fields(next_step);
                resp_seen <= 1'b0;
                if (next_step == S_CMD0)   cmd0_count <= cmd0_count + 4'd1;
                if (next_step == S_ACMD41) pair_count <= pair_count + 16'd1;
            end

            if ((state == ST_WAIT) && response_ready) begin
                resp_q    <= response;
                resp_seen <= 1'b1;
            end

            if (start_accept) begin
                cmd0_count <= '0;
                pair_count <= '0;
                err_code   <= ERR_NONE;
            end else if (next_state == ST_ERROR) begin
                err_code <= next_err;
            end
        end
    end

endmodule

// File: tb/tb_sd_init_seq.sv
// ---------------------------------------------------------------------------
// tb_sd_init_seq
// Self-checking bench for sd_init_seq. A card model answers each go with an
// R1 byte chosen per scenario; a table of scenarios gives the expected command
// sequence (0=CMD0 8=CMD8 A=CMD55 B=ACMD41 C=CMD16) and the final status.
// Hand-written sequences cover power-up delay, watchdog latency, start while
// busy and reset mid power-up.
// ---------------------------------------------------------------------------
module tb_sd_init_seq;

    localparam int NVEC = 10;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        init_done;
    logic        init_error;
    logic [2:0]  err_code;
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic        go;
    logic        ignore_count;
    logic        cmd_done;
    logic [7:0]  response;
    logic        response_ready;

    typedef struct {
        string      name;
        int         cmd0_fail;
        logic [7:0] r8;
        logic [7:0] r55;
        int         a41_busy;
        logic [7:0] a41_final;
        logic [7:0] r16;
        int         mode;
        string      exp_seq;
        logic       exp_done;
        logic [2:0] exp_code;
    } vec_t;

    vec_t  vecs[NVEC+1];
    vec_t  cfg;
    string seq_log;
    int    cmd0_seen;
    int    a41_seen;
    int    last_done;
    int    cyc;
    int    n_compared;
    int    n_mismatched;

    sd_init_seq #(
        .POWERUP_CYCLES (16'd20),
        .CMD0_RETRIES   (4'd3),
        .ACMD41_RETRIES (16'd4),
        .CMD_TIMEOUT    (24'd100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .busy           (busy),
        .init_done      (init_done),
        .init_error     (init_error),
        .err_code       (err_code),
        .cmd            (cmd),
        .arg            (arg),
        .go             (go),
        .ignore_count   (ignore_count),
        .cmd_done       (cmd_done),
        .response       (response),
        .response_ready (response_ready)
    );

    // Free-running clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Absolute safety net so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got simulation still running, expected finished");
        $fatal(1, "[TB] global timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkSeq(input string name, input string actual, input string expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got \"%s\", expected \"%s\"", name, actual, expected);
        end
    endtask

    task automatic setVec(input int i, input string nm, input int c0f,
                          input logic [7:0] r8, input logic [7:0] r55,
                          input int a41b, input logic [7:0] a41f,
                          input logic [7:0] r16, input int mode,
                          input string seq, input logic done, input logic [2:0] code);
        vecs[i].name      = nm;
        vecs[i].cmd0_fail = c0f;
        vecs[i].r8        = r8;
        vecs[i].r55       = r55;
        vecs[i].a41_busy  = a41b;
        vecs[i].a41_final = a41f;
        vecs[i].r16       = r16;
        vecs[i].mode      = mode;
        vecs[i].exp_seq   = seq;
        vecs[i].exp_done  = done;
        vecs[i].exp_code  = code;
    endtask

    // Load a scenario into the card model and pulse start; returns #1 after
    // the edge that sampled start.
    task automatic applyStimulus(input int idx);
        cfg       = vecs[idx];
        seq_log   = "";
        cmd0_seen = 0;
        a41_seen  = 0;
        last_done = -1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int limit);
        int n;
        n = 0;
        while (busy === 1'b1 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({name, "_reached_idle"}, {31'd0, busy}, 32'd0);
    endtask

    function automatic string cmdChar(input logic [5:0] c);
        case (c)
            6'd0:    return "0";
            6'd8:    return "8";
            6'd55:   return "A";
            6'd41:   return "B";
            6'd16:   return "C";
            default: return "?";
        endcase
    endfunction

    function automatic logic [31:0] expArg(input logic [5:0] c);
        case (c)
            6'd8:    return 32'h0000_01AA;
            6'd41:   return 32'h4000_0000;
            6'd16:   return 32'h0000_0200;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Card model. Mode 0: response 3 cycles after go, cmd_done one cycle
    // later. Mode 1: response and cmd_done together. Mode 2: cmd_done with no
    // response. Mode 3: never answers.
    initial begin : card_model
        logic [7:0] r;
        cmd_done       = 1'b0;
        response_ready = 1'b0;
        response       = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (go === 1'b1) begin
                seq_log = {seq_log, cmdChar(cmd)};
                checkOutput("go_arg", arg, expArg(cmd));
                checkOutput("go_ignore_count", {31'd0, ignore_count},
                            (cmd == 6'd8) ? 32'd1 : 32'd0);
                if (last_done >= 0)
                    checkOutput("done_to_go_gap", cyc - last_done, 32'd2);
                case (cmd)
                    6'd0: begin
                        r = (cmd0_seen < cfg.cmd0_fail) ? 8'hFF : 8'h01;
                        cmd0_seen++;
                    end
                    6'd8:  r = cfg.r8;
                    6'd55: r = cfg.r55;
                    6'd41: begin
                        r = (a41_seen < cfg.a41_busy) ? 8'h01 : cfg.a41_final;
                        a41_seen++;
                    end
                    6'd16:   r = cfg.r16;
                    default: r = 8'hFF;
                endcase
                if (cfg.mode != 3) begin
                    repeat (3) @(posedge clk);
                    #1;
                    if (cfg.mode == 0) begin
                        response_ready = 1'b1;
                        response       = r;
                        @(posedge clk); #1;
                        response_ready = 1'b0;
                        cmd_done       = 1'b1;
                    end else if (cfg.mode == 1) begin
                        response_ready = 1'b1;
                        response       = r;
                        cmd_done       = 1'b1;
                    end else begin
                        cmd_done = 1'b1;
                    end
                    last_done = cyc;
                    @(posedge clk); #1;
                    response_ready = 1'b0;
                    cmd_done       = 1'b0;
                end
            end
        end
    end

    initial begin : main
        int n;
        int go_seen;
        cyc          = 0;
        n_compared   = 0;
        n_mismatched = 0;
        seq_log      = "";
        last_done    = -1;
        rst          = 1'b1;
        start        = 1'b0;

        //            idx name          c0f r8     r55    a41b a41f   r16    mode seq             done code
        setVec(0,  "happy",          0, 8'h01, 8'h01, 1,  8'h00, 8'h00, 0, "08ABABC",    1'b1, 3'd0);
        setVec(1,  "cmd0_always_ff", 99, 8'h01, 8'h01, 0,  8'h00, 8'h00, 0, "000",        1'b0, 3'd1);
        setVec(2,  "cmd8_v1_card",   0, 8'h05, 8'h01, 0,  8'h00, 8'h00, 0, "08",         1'b0, 3'd2);
        setVec(3,  "acmd41_busy",    0, 8'h01, 8'h01, 99, 8'h01, 8'h00, 0, "08ABABABAB", 1'b0, 3'd3);
        setVec(4,  "cmd0_third_ok",  2, 8'h01, 8'h01, 0,  8'h00, 8'h00, 1, "0008ABC",    1'b1, 3'd0);
        setVec(5,  "acmd41_bad",     0, 8'h01, 8'h00, 0,  8'h03, 8'h00, 1, "08AB",       1'b0, 3'd3);
        setVec(6,  "cmd55_bad",      0, 8'h01, 8'h04, 0,  8'h00, 8'h00, 0, "08A",        1'b0, 3'd6);
        setVec(7,  "cmd16_bad",      0, 8'h01, 8'h01, 0,  8'h00, 8'h40, 1, "08ABC",      1'b0, 3'd4);
        setVec(8,  "no_response",    0, 8'h01, 8'h01, 0,  8'h00, 8'h00, 2, "0",          1'b0, 3'd5);
        setVec(9,  "acmd41_at_limit", 0, 8'h01, 8'h01, 3, 8'h00, 8'h00, 0, "08ABABABABC", 1'b1, 3'd0);
        setVec(10, "timeout",        0, 8'h01, 8'h01, 0,  8'h00, 8'h00, 3, "0",          1'b0, 3'd5);
        cfg = vecs[0];

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy",         {31'd0, busy},         32'd0);
        checkOutput("reset_init_done",    {31'd0, init_done},    32'd0);
        checkOutput("reset_init_error",   {31'd0, init_error},   32'd0);
        checkOutput("reset_err_code",     {29'd0, err_code},     32'd0);
        checkOutput("reset_cmd",          {26'd0, cmd},          32'd0);
        checkOutput("reset_arg",          arg,                   32'd0);
        checkOutput("reset_go",           {31'd0, go},           32'd0);
        checkOutput("reset_ignore_count", {31'd0, ignore_count}, 32'd0);
        rst = 1'b0;

        // Table-driven scenarios
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(i);
            checkOutput({vecs[i].name, "_busy_after_start"}, {31'd0, busy}, 32'd1);
            checkOutput({vecs[i].name, "_flags_cleared"},
                        {30'd0, init_done, init_error}, 32'd0);
            waitIdle(vecs[i].name, 3000);
            checkSeq({vecs[i].name, "_go_sequence"}, seq_log, vecs[i].exp_seq);
            checkOutput({vecs[i].name, "_init_done"}, {31'd0, init_done},
                        {31'd0, vecs[i].exp_done});
            checkOutput({vecs[i].name, "_init_error"}, {31'd0, init_error},
                        {31'd0, !vecs[i].exp_done});
            checkOutput({vecs[i].name, "_err_code"}, {29'd0, err_code},
                        {29'd0, vecs[i].exp_code});
        end

        // start while busy must not restart the sequence
        applyStimulus(0);
        repeat (30) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("start_ignored_busy", {31'd0, busy}, 32'd1);
        waitIdle("start_ignored", 3000);
        checkSeq("start_ignored_go_sequence", seq_log, "08ABABC");
        checkOutput("start_ignored_init_done", {31'd0, init_done}, 32'd1);

        // rst during power-up: everything back to reset values, no go
        applyStimulus(0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("midrst_busy",         {31'd0, busy},         32'd0);
        checkOutput("midrst_init_done",    {31'd0, init_done},    32'd0);
        checkOutput("midrst_init_error",   {31'd0, init_error},   32'd0);
        checkOutput("midrst_err_code",     {29'd0, err_code},     32'd0);
        checkOutput("midrst_cmd",          {26'd0, cmd},          32'd0);
        checkOutput("midrst_arg",          arg,                   32'd0);
        checkOutput("midrst_go",           {31'd0, go},           32'd0);
        checkOutput("midrst_ignore_count", {31'd0, ignore_count}, 32'd0);
        rst = 1'b0;
        go_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (go === 1'b1) go_seen++;
        end
        checkOutput("midrst_no_go", go_seen, 32'd0);
        checkOutput("midrst_stays_idle", {31'd0, busy}, 32'd0);

        // Watchdog: card never completes; power-up delay and timeout latency
        applyStimulus(10);
        n = 0;
        while (go !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("timeout_first_go", {31'd0, go}, 32'd1);
        checkOutput("powerup_delay", n, 32'd20);
        n = 0;
        while (init_error !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("timeout_latency", n, 32'd100);
        checkOutput("timeout_err_code", {29'd0, err_code}, 32'd5);
        checkOutput("timeout_busy", {31'd0, busy}, 32'd0);
        checkSeq("timeout_go_sequence", seq_log, "0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
